// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: scans eight latched segment patterns onto a shared bus with one-hot digit selects
// Ports: Clock/Reset (sync, active-high), Enable (scan on/off), Video_Output0..7 (per-digit patterns),
//        Seg_Out (shared segments), Digit_Sel (digit enables), Digit_Index (slot index), Frame_Done (wrap pulse)
module seven_seg_scan_driver #(
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 64,
    parameter bit SEL_ACT_LOW  = 1,
    parameter bit SEG_ACT_LOW  = 1
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Enable,
    input  logic [6:0] Video_Output0,
    input  logic [6:0] Video_Output1,
    input  logic [6:0] Video_Output2,
    input  logic [6:0] Video_Output3,
    input  logic [6:0] Video_Output4,
    input  logic [6:0] Video_Output5,
    input  logic [6:0] Video_Output6,
    input  logic [6:0] Video_Output7,
    output logic [6:0] Seg_Out,
    output logic [7:0] Digit_Sel,
    output logic [2:0] Digit_Index,
    output logic       Frame_Done
);
    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [6:0] SEG_OFF = SEG_ACT_LOW ? 7'h7F : 7'h00;
    localparam logic [7:0] SEL_OFF = SEL_ACT_LOW ? 8'hFF : 8'h00;
    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] idx, idx_n;
    logic [6:0] vin [8];
    logic [6:0] shadow [8];
    logic [6:0] shadow_n [8];
    logic [6:0] seg_n;
    logic [7:0] sel_n;
    logic frame_n, wrap;
    assign vin = '{Video_Output0, Video_Output1, Video_Output2, Video_Output3,
                   Video_Output4, Video_Output5, Video_Output6, Video_Output7};
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        idx_n = idx;
        shadow_n = shadow;
        seg_n = SEG_OFF;
        sel_n = SEL_OFF;
        frame_n = 1'b0;
        wrap = state != IDLE && cnt == LAST && idx == 3'd7;
        // shadow tracks the inputs while idle so a restart shows fresh data
        if (Reset || state == IDLE || wrap)
            shadow_n = vin;
        if (!Enable) begin
            state_n = IDLE;
            cnt_n = '0;
            idx_n = '0;
        end else if (state == IDLE) begin
            state_n = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
            cnt_n = '0;
            idx_n = '0;
        end else begin
            cnt_n = (cnt == LAST) ? '0 : cnt + 1'b1;
            idx_n = (cnt == LAST) ? idx + 3'd1 : idx;
            state_n = (cnt_n < BLANK_END) ? BLANK : DRIVE;
            frame_n = wrap;
        end
        // outputs are derived from the next state so they line up with it after the edge
        if (state_n == DRIVE) begin
            seg_n = shadow_n[idx_n];
            sel_n = SEL_ACT_LOW ? ~(8'd1 << idx_n) : (8'd1 << idx_n);
        end
    end
    always_ff @(posedge Clock) begin
        shadow <= shadow_n;
        if (Reset) begin
            state <= IDLE;
            cnt <= '0;
            idx <= '0;
            Seg_Out <= SEG_OFF;
            Digit_Sel <= SEL_OFF;
            Digit_Index <= '0;
            Frame_Done <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            idx <= idx_n;
            Seg_Out <= seg_n;
            Digit_Sel <= sel_n;
            Digit_Index <= idx_n;
            Frame_Done <= frame_n;
        end
    end
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: scoreboard bench against a tick-count reference model
module tb_seven_seg_scan_driver;
    localparam int P = 4;
    localparam int B = 1;
    typedef struct packed {
        logic [6:0] seg;
        logic [7:0] sel;
        logic [2:0] index;
        logic       done;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b1;
    logic [6:0] v [8];
    logic [6:0] seg_out;
    logic [7:0] digit_sel;
    logic [2:0] digit_index;
    logic frame_done;
    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;
    bit active = 0;
    int t = 0;
    logic [6:0] frame [8];
    always #5 clk = ~clk;
    seven_seg_scan_driver #(.PRESCALE(P), .BLANK_CYCLES(B), .SEL_ACT_LOW(1), .SEG_ACT_LOW(1)) dut (
        .Clock(clk), .Reset(rst), .Enable(en),
        .Video_Output0(v[0]), .Video_Output1(v[1]), .Video_Output2(v[2]), .Video_Output3(v[3]),
        .Video_Output4(v[4]), .Video_Output5(v[5]), .Video_Output6(v[6]), .Video_Output7(v[7]),
        .Seg_Out(seg_out), .Digit_Sel(digit_sel), .Digit_Index(digit_index), .Frame_Done(frame_done)
    );
    // Model: t counts cycles since the scan started; slot and phase follow by division.
    task automatic apply(input logic r, input logic e);
        exp_t x;
        int slot;
        rst = r;
        en = e;
        x = '{seg: 7'h7F, sel: 8'hFF, index: 3'd0, done: 1'b0};
        if (r) begin
            active = 0;
            frame = v;
        end else if (!active) begin
            frame = v;
            if (e) begin
                active = 1;
                t = 0;
            end
        end else if (!e) begin
            active = 0;
        end else begin
            t++;
            if (t % (8 * P) == 0) begin
                frame = v;
                x.done = 1'b1;
            end
        end
        if (active) begin
            slot = (t / P) % 8;
            x.index = slot[2:0];
            if (t % P >= B) begin
                x.sel = ~(8'd1 << slot);
                x.seg = frame[slot];
            end
        end
        q.push_back(x);
        @(negedge clk);
        #1;
    endtask
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            vectors++;
            if ({seg_out, digit_sel, digit_index, frame_done} !== e) begin
                miscompares++;
                $display("FAIL outputs @%0t: got seg=%h sel=%h idx=%0d done=%b, want seg=%h sel=%h idx=%0d done=%b",
                         $time, seg_out, digit_sel, digit_index, frame_done, e.seg, e.sel, e.index, e.done);
            end
            vectors++;
            if ($countones(~digit_sel) > 1 || $isunknown(digit_sel)) begin
                miscompares++;
                $display("FAIL onehot @%0t: got sel=%h, want at most one active", $time, digit_sel);
            end
        end
    end
    initial begin
        logic ecur;
        for (int i = 0; i < 8; i++) v[i] = 7'h10 + 7'(i);
        @(negedge clk);
        #1;
        apply(1, 1);
        apply(1, 1);
        for (int i = 0; i < 41; i++) apply(0, 1);
        for (int k = 0; k < 64 && (t % 32) / P != 2; k++) apply(0, 1);
        v[5] = 7'h2A;
        for (int i = 0; i < 40; i++) apply(0, 1);
        for (int k = 0; k < 64 && t % 32 != 3 * P + 2; k++) apply(0, 1);
        apply(0, 0);
        apply(0, 0);
        for (int i = 0; i < 40; i++) apply(0, 1);
        for (int k = 0; k < 64 && !((t % 32) / P == 6 && t % P >= B); k++) apply(0, 1);
        apply(1, 1);
        for (int i = 0; i < 20; i++) apply(0, 1);
        ecur = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) v[$urandom_range(7)] = 7'($urandom);
            if ($urandom_range(49) == 0) ecur = ~ecur;
            apply($urandom_range(199) == 0, ecur);
        end
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
